// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and constants for the serial parity checker
//
// Provides the checker FSM state type, the parity mode encodings and the
// helper that sizes the bit-position index from the data width.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Bits needed to address data bits 0..data_w-1; never less than one bit.
    function automatic int idx_width(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/parity_sat_counter.sv
// rtl/parity_sat_counter.sv - saturating event counter with clear priority
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   inc    in   count one event this cycle
//   clr    in   synchronous clear; wins over inc
//   count  out  CNT_W current count, sticks at all-ones
module parity_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_stream_checker.sv
// rtl/parity_stream_checker.sv - bit-serial frame parity checker with error count
//
// Frames are DATA_W data bits (LSB first) followed by one parity bit.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bit_valid   bit_in is valid this cycle
//   bit_in      serial bit
//   sof         start of frame (with bit_valid), marks data bit 0
//   odd_mode    parity sense, sampled on the sof beat (0 even, 1 odd)
//   clr_cnt     synchronous clear of err_cnt
//   word_out    reassembled word, valid with done
//   done        one-cycle frame-complete pulse
//   check       parity error flag, valid with done
//   abort       one-cycle pulse when a frame is dropped by an early sof
//   err_cnt     saturating count of frames with check=1
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sof,
    input  logic              odd_mode,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] word_out,
    output logic              done,
    output logic              check,
    output logic              abort,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                IDX_W    = idx_width(DATA_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic              acc;
    logic              odd_lat;

    logic              start;
    logic              drop;
    logic              shift;
    logic              par_beat;
    logic              check_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A valid sof restarts a frame from any state.
    always_comb begin
        state_nxt = state;
        if (bit_valid) begin
            if (sof) begin
                state_nxt = DATA;
            end else begin
                case (state)
                    DATA:    if (idx == LAST_IDX) state_nxt = PAR;
                    PAR:     state_nxt = IDLE;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_comb begin
        start     = bit_valid && sof;
        drop      = start && (state != IDLE);
        shift     = bit_valid && !sof && (state == DATA);
        par_beat  = bit_valid && !sof && (state == PAR);
        check_nxt = acc ^ bit_in ^ (odd_lat == PAR_ODD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            idx     <= '0;
            acc     <= 1'b0;
            odd_lat <= PAR_EVEN;
        end else if (start) begin
            shreg   <= DATA_W'(bit_in);
            idx     <= IDX_W'(1);
            acc     <= bit_in;
            odd_lat <= odd_mode;
        end else if (shift) begin
            shreg[idx] <= bit_in;
            idx        <= idx + IDX_W'(1);
            acc        <= acc ^ bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out <= '0;
            done     <= 1'b0;
            check    <= 1'b0;
            abort    <= 1'b0;
        end else begin
            done  <= par_beat;
            abort <= drop;
            if (par_beat) begin
                word_out <= shreg;
                check    <= check_nxt;
            end
        end
    end

    // Registered alongside done so the count moves in the same cycle.
    parity_sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (par_beat && check_nxt),
        .clr   (clr_cnt),
        .count (err_cnt)
    );

endmodule

// File: tb/tb_parity_stream_checker.sv
// tb/tb_parity_stream_checker.sv - scoreboard bench for parity_stream_checker
module tb_parity_stream_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_in = 1'b0;
    logic sof = 1'b0;
    logic odd_mode = 1'b0;
    logic clr_cnt = 1'b0;

    logic [7:0]  word_a, word_b;
    logic        done_a, done_b, check_a, check_b, abort_a, abort_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    parity_stream_checker #(.DATA_W(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .sof(sof), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
        .word_out(word_a), .done(done_a), .check(check_a), .abort(abort_a),
        .err_cnt(cnt_a)
    );

    parity_stream_checker #(.DATA_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
        .sof(sof), .odd_mode(odd_mode), .clr_cnt(clr_cnt),
        .word_out(word_b), .done(done_b), .check(check_b), .abort(abort_b),
        .err_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  word;
        logic        chk;
        logic [15:0] cnt_a;
        logic [1:0]  cnt_b;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int aborts_a = 0;
    int aborts_b = 0;
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (abort_a) aborts_a++;
            if (abort_b) aborts_b++;
            if (done_a || done_b) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_a=%0b done_b=%0b expected no done", done_a, done_b);
                end else begin
                    mon_e = sb.pop_front();
                    cmp("done_a", 32'(done_a), 32'd1);
                    cmp("done_b", 32'(done_b), 32'd1);
                    cmp("word_a", 32'(word_a), 32'(mon_e.word));
                    cmp("word_b", 32'(word_b), 32'(mon_e.word));
                    cmp("check_a", 32'(check_a), 32'(mon_e.chk));
                    cmp("check_b", 32'(check_b), 32'(mon_e.chk));
                    cmp("err_cnt_a", 32'(cnt_a), 32'(mon_e.cnt_a));
                    cmp("err_cnt_b", 32'(cnt_b), 32'(mon_e.cnt_b));
                    cmp("done_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One beat presented, consumed at the next rising edge; returns at edge+1.
    task automatic beat(input logic b, input logic s, input logic odd, input logic clr);
        bit_valid = 1'b1;
        bit_in    = b;
        sof       = s;
        odd_mode  = odd;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        sof       = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    // odd_mode is driven inverted on non-sof beats to prove it is latched.
    task automatic send_frame(input logic [7:0] w, input logic p, input logic odd,
                              input logic exp_chk, input int maxgap, input logic clr_par);
        int g;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            idle_cycles(g);
            beat((i < 8) ? w[i] : p, i == 0, (i == 0) ? odd : ~odd, (i == 8) && clr_par);
            if (i == 8) begin
                if (clr_par) begin
                    exp_cnt_a = 0;
                    exp_cnt_b = 0;
                end else if (exp_chk) begin
                    if (exp_cnt_a < 65535) exp_cnt_a++;
                    if (exp_cnt_b < 3) exp_cnt_b++;
                end
                e.word  = w;
                e.chk   = exp_chk;
                e.cnt_a = 16'(exp_cnt_a);
                e.cnt_b = 2'(exp_cnt_b);
                e.cyc   = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_partial(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            beat(w[i], i == 0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_word_a"}, 32'(word_a), 32'd0);
        cmp({tag, "_done_a"}, 32'(done_a), 32'd0);
        cmp({tag, "_check_a"}, 32'(check_a), 32'd0);
        cmp({tag, "_abort_a"}, 32'(abort_a), 32'd0);
        cmp({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        cmp({tag, "_word_b"}, 32'(word_b), 32'd0);
        cmp({tag, "_check_b"}, 32'(check_b), 32'd0);
        cmp({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle_cycles(2);

        // Even 0xA5, correct parity; then wrong parity; then odd 0x07.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle_cycles(2);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        idle_cycles(2);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle_cycles(2);

        // Stray bits in IDLE, then 0x3C with random gaps.
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        idle_cycles(2);

        // Early sof at data bit 5, then a full 0xFF frame.
        send_partial(8'h5A, 5);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle_cycles(3);
        cmp("abort_count_a", 32'(aborts_a), 32'd1);
        cmp("abort_count_b", 32'(aborts_b), 32'd1);

        // Stand-alone clear, then error frames back to back, clear on the sixth.
        beat(1'b0, 1'b0, 1'b0, 1'b1);
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        idle_cycles(1);
        cmp("clr_cnt_a", 32'(cnt_a), 32'd0);
        cmp("clr_cnt_b", 32'(cnt_b), 32'd0);
        for (int k = 0; k < 5; k++) send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        idle_cycles(2);

        // Asynchronous reset mid-frame after data bit 4.
        send_partial(8'hFF, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        @(posedge clk);
        #1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle_cycles(5);

        cmp("pending_frames", 32'(sb.size()), 32'd0);
        cmp("abort_total_a", 32'(aborts_a), 32'd1);
        cmp("abort_total_b", 32'(aborts_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Bit-serial parity checker, the parametrised successor to the team's 4-input combinational even-parity checker. It accepts frames of DATA_W data bits followed by one parity bit, LSB first. It reassembles each data word, checks it against even or odd parity (selectable per frame), and reports a registered result with an error flag. A saturating error counter sits behind the result for link-quality monitoring on serial receive paths.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (≥2)
- CNT_W, 16, width of saturating error counter (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- bit_valid  in  1  bit_in is valid this cycle
- bit_in  in  1  serial bit
- sof  in  1  start of frame; qualified by bit_valid; marks data bit 0
- odd_mode  in  1  0 = even parity, 1 = odd; sampled on the sof beat
- clr_cnt  in  1  synchronous clear of err_cnt
- word_out  out  DATA_W  reassembled data word, valid with done
- done  out  1  one-cycle pulse: frame complete
- check  out  1  parity error flag, valid with done (1 = error)
- abort  out  1  one-cycle pulse: frame discarded by an early sof
- err_cnt  out  CNT_W  count of frames with check=1, saturating

## Operation
- FSM states: IDLE, DATA, PAR.
- IDLE:
  - bit_valid&sof → capture bit 0 and latch odd_mode → DATA (or PAR if DATA_W=1, not supported).
  - bit_valid without sof is ignored.
- DATA:
  - Each bit_valid shifts bit_in into position idx, with idx going 1..DATA_W-1.
  - Running parity acc ^= bit_in.
  - After bit DATA_W-1 → PAR.
- PAR:
  - The bit_valid beat is the parity bit.
  - check = acc ^ bit_in ^ odd_mode_latched; even mode errors when the total ones count is odd.
  - → IDLE.
- sof with bit_valid while in DATA or PAR:
  - Current frame is dropped and abort pulses.
  - No done, no count.
  - That beat becomes bit 0 of a new frame; state goes to DATA and odd_mode is re-latched.
- Gaps (bit_valid=0) in any state hold all state; there is no timeout.
- err_cnt:
  - Increments on a done with check=1.
  - Saturates at 2^CNT_W−1.
  - clr_cnt has priority over an increment in the same cycle, so the result is 0.
- word_out and check hold their last values between done pulses.

## Timing
- Reset values: word_out=0, done=0, check=0, abort=0, err_cnt=0, FSM=IDLE, acc=0, idx=0.
- Reset mid-frame discards the frame silently, with no abort pulse.
- done, check and word_out are registered and appear in the cycle after the parity bit is accepted (latency 1).
- Minimum frame is DATA_W+1 consecutive valid beats. Back-to-back frames are allowed: sof may arrive in the cycle after the parity beat (FSM is in IDLE).
- abort is asserted in the cycle after the offending sof beat.
- err_cnt updates in the same cycle done is asserted.
- clr_cnt takes effect on the next edge.

## Structure
- Package parity_pkg:
  - state enum (IDLE, DATA, PAR)
  - constant function for idx width, clog2(DATA_W)
  - mode encodings PAR_EVEN=0, PAR_ODD=1
- One sub-module, parity_sat_counter (CNT_W-parametrised saturating counter with inc and clr, clr priority), reusable by other link monitors.
- FSM, shift register and accumulator stay in the top module.

## Test plan
DATA_W=8, CNT_W=16 unless noted.
- Even mode, sof + 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0 → done one cycle later, word_out=0xA5, check=0, err_cnt=0.
- Same frame with parity 1, then odd mode 0x07 with parity 0 → first frame check=1 and err_cnt=1; second frame check=0 and err_cnt stays 1.
- 0x3C with random bit_valid gaps of 0–3 cycles between beats, plus bit_valid=1 without sof in IDLE beforehand → stray bits ignored, word_out=0x3C, check correct, a single done.
- sof at data bit 5, followed by a full frame 0xFF with parity 0 → abort pulses once; then done with word_out=0xFF, check=0, err_cnt unchanged.
- CNT_W=2, five erroneous frames, then clr_cnt asserted on the beat that produces a sixth error → err_cnt sequence 1,2,3,3,3, then 0.
- rst_n low for 1 cycle after data bit 4 (asynchronous, mid-cycle), then a clean frame 0x81 with parity 0 → all outputs 0 during reset, no abort, then done with word_out=0x81, check=0.
